// File: rtl/sweep_decoder.sv
// Registered N-to-M one-hot decoder with enable gating, out-of-range
// flagging and a sweep mode that walks a single high line across every
// output, one per cycle, for bulk clear/initialisation of the register file.
module sweep_decoder #(
    parameter int SEL_W   = 4,
    parameter int NUM_OUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sweep_start,
    input  logic               sweep_hold,
    output logic [NUM_OUT-1:0] enable,
    output logic               sel_err,
    output logic               sweep_busy,
    output logic               sweep_done
);

    localparam int                 CNT_W     = $clog2(NUM_OUT);
    localparam logic [SEL_W:0]     NUM_OUT_W = (SEL_W+1)'(NUM_OUT);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] LINE0     = {{(NUM_OUT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [NUM_OUT-1:0] enable_r;
    logic [NUM_OUT-1:0] enable_nxt_s;
    logic               sel_err_r;
    logic               sel_err_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic               done_r;
    logic               done_nxt_s;
    logic               in_range_s;

    // Compare-per-line decode: an unknown index matches no line, so the
    // result is all-zero rather than X, and at most one bit can ever be set.
    function automatic logic [NUM_OUT-1:0] decode_line(input logic [SEL_W-1:0] idx);
        logic [NUM_OUT-1:0] line;
        line = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if ({1'b0, idx} == (SEL_W+1)'(i)) begin
                line[i] = 1'b1;
            end else begin
                line[i] = 1'b0;
            end
        end
        return line;
    endfunction

    // Widened compare so NUM_OUT == 2**SEL_W fits; then it folds to constant true.
    assign in_range_s = ({1'b0, sel} < NUM_OUT_W);

    // State register, sweep index and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            enable_r  <= '0;
            sel_err_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            enable_r  <= enable_nxt_s;
            sel_err_r <= sel_err_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    // Next-state selection: sweep start wins in IDLE, hold freezes SWEEP.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sweep_start) begin
                    state_nxt_s = ST_SWEEP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (sweep_hold) begin
                    state_nxt_s = ST_SWEEP;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SWEEP;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the sweep index.
    always_comb begin
        cnt_nxt_s     = '0;
        enable_nxt_s  = '0;
        sel_err_nxt_s = 1'b0;
        busy_nxt_s    = 1'b0;
        done_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sweep_start) begin
                    enable_nxt_s = LINE0;
                    busy_nxt_s   = 1'b1;
                end else begin
                    if (en && in_range_s) begin
                        enable_nxt_s = decode_line(sel);
                    end else begin
                        enable_nxt_s = '0;
                    end
                    if (en && !in_range_s) begin
                        sel_err_nxt_s = 1'b1;
                    end else begin
                        sel_err_nxt_s = 1'b0;
                    end
                end
            end
            ST_SWEEP: begin
                if (sweep_hold) begin
                    cnt_nxt_s    = cnt_r;
                    enable_nxt_s = enable_r;
                    busy_nxt_s   = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    done_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s    = cnt_r + CNT_W'(1);
                    enable_nxt_s = {enable_r[NUM_OUT-2:0], 1'b0};
                    busy_nxt_s   = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_nxt_s = '0;
            end
            default: begin
                cnt_nxt_s = '0;
            end
        endcase
    end

    assign enable     = enable_r;
    assign sel_err    = sel_err_r;
    assign sweep_busy = busy_r;
    assign sweep_done = done_r;

endmodule
